// File: rtl/alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl
//
// Issue/writeback controller sitting in front of the 8-bit arithmetic cells
// (sum, minus, multiply, division, compare). One operation is accepted per
// in_valid/in_ready handshake. Its operands are registered onto cell_a/cell_b
// and held stable for the execution window. The selected cell output is then
// captured into a 16-bit result register and offered downstream via
// out_valid/out_ready. An 8-bit accumulator holds the low byte of the last
// completed result so that operations can be chained (in_use_acc).
//
// Parameters
//   MULDIV_WAIT : extra EXEC cycles for MUL/DIV (multicycle cells), 0..7
//
// Ports
//   clk, reset            : clock (rising edge), synchronous active-high reset
//   in_valid/in_ready     : operation handshake
//   in_op                 : 0 ADD 1 SUB 2 MUL 3 DIV 4 CMP_EQ 5 CMP_GT 6 CMP_LT 7 CLRACC
//   in_a, in_b            : operands; in_use_acc replaces in_a with acc
//   cell_a, cell_b        : registered operands fed to every cell
//   cmp_sel               : compare cell function (0 ==, 1 >, 2 <)
//   sum_in .. cmp_in      : cell outputs
//   out_valid/out_ready   : result handshake
//   out_result            : registered result
//   out_zero, out_divz    : result == 0, last op was DIV by zero
//   acc                   : accumulator
// ---------------------------------------------------------------------------
module alu_issue_ctrl #(
    parameter int MULDIV_WAIT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_op,
    input  logic [7:0]  in_a,
    input  logic [7:0]  in_b,
    input  logic        in_use_acc,
    output logic [7:0]  cell_a,
    output logic [7:0]  cell_b,
    output logic [1:0]  cmp_sel,
    input  logic [7:0]  sum_in,
    input  logic [7:0]  minus_in,
    input  logic [7:0]  quot_in,
    input  logic [7:0]  rem_in,
    input  logic [15:0] mul_in,
    input  logic        cmp_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_result,
    output logic        out_zero,
    output logic        out_divz,
    output logic [7:0]  acc
);

    localparam logic [2:0] OP_ADD    = 3'd0;
    localparam logic [2:0] OP_SUB    = 3'd1;
    localparam logic [2:0] OP_MUL    = 3'd2;
    localparam logic [2:0] OP_DIV    = 3'd3;
    localparam logic [2:0] OP_CMP_EQ = 3'd4;
    localparam logic [2:0] OP_CMP_GT = 3'd5;
    localparam logic [2:0] OP_CMP_LT = 3'd6;
    localparam logic [2:0] OP_CLRACC = 3'd7;

    localparam logic [2:0] WAIT_CYCLES = 3'(MULDIV_WAIT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_DONE
    } state_t;

    state_t      state_q,   state_d;
    logic [2:0]  op_q,      op_d;
    logic [2:0]  cnt_q,     cnt_d;
    logic [7:0]  cell_a_q,  cell_a_d;
    logic [7:0]  cell_b_q,  cell_b_d;
    logic [1:0]  cmp_sel_q, cmp_sel_d;
    logic [15:0] result_q,  result_d;
    logic        zero_q,    zero_d;
    logic        divz_q,    divz_d;
    logic [7:0]  acc_q,     acc_d;

    logic [15:0] cell_result;
    logic        div_by_zero;

    // Result selection from the cell outputs for the op being executed.
    always_comb begin
        cell_result = 16'h0000;
        div_by_zero = (op_q == OP_DIV) && (cell_b_q == 8'h00);
        case (op_q)
            OP_ADD:    cell_result = {8'h00, sum_in};
            OP_SUB:    cell_result = {8'h00, minus_in};
            OP_MUL:    cell_result = mul_in;
            OP_DIV:    cell_result = div_by_zero ? 16'h0000 : {rem_in, quot_in};
            OP_CMP_EQ,
            OP_CMP_GT,
            OP_CMP_LT: cell_result = {15'b0, cmp_in};
            OP_CLRACC: cell_result = 16'h0000;
            default:   cell_result = 16'h0000;
        endcase
    end

    // Next-state and datapath update.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        cell_a_d  = cell_a_q;
        cell_b_d  = cell_b_q;
        cmp_sel_d = cmp_sel_q;
        result_d  = result_q;
        zero_d    = zero_q;
        divz_d    = divz_q;
        acc_d     = acc_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    op_d     = in_op;
                    cell_a_d = in_use_acc ? acc_q : in_a;
                    cell_b_d = in_b;
                    // Compare select only changes for compare ops so the
                    // compare cell input is quiet during other operations.
                    case (in_op)
                        OP_CMP_EQ: cmp_sel_d = 2'd0;
                        OP_CMP_GT: cmp_sel_d = 2'd1;
                        OP_CMP_LT: cmp_sel_d = 2'd2;
                        default:   cmp_sel_d = cmp_sel_q;
                    endcase
                    cnt_d   = (in_op == OP_MUL || in_op == OP_DIV) ? WAIT_CYCLES : 3'd0;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (cnt_q != 3'd0) begin
                    cnt_d = cnt_q - 3'd1;
                end else begin
                    result_d = cell_result;
                    zero_d   = (cell_result == 16'h0000);
                    divz_d   = div_by_zero;
                    acc_d    = cell_result[7:0];
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            op_q      <= OP_ADD;
            cnt_q     <= 3'd0;
            cell_a_q  <= 8'h00;
            cell_b_q  <= 8'h00;
            cmp_sel_q <= 2'd0;
            result_q  <= 16'h0000;
            zero_q    <= 1'b0;
            divz_q    <= 1'b0;
            acc_q     <= 8'h00;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            cell_a_q  <= cell_a_d;
            cell_b_q  <= cell_b_d;
            cmp_sel_q <= cmp_sel_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            divz_q    <= divz_d;
            acc_q     <= acc_d;
        end
    end

    // in_ready is gated by reset so nothing is offered while reset is held.
    assign in_ready   = (state_q == S_IDLE) && !reset;
    assign out_valid  = (state_q == S_DONE);
    assign cell_a     = cell_a_q;
    assign cell_b     = cell_b_q;
    assign cmp_sel    = cmp_sel_q;
    assign out_result = result_q;
    assign out_zero   = zero_q;
    assign out_divz   = divz_q;
    assign acc        = acc_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_ctrl
//
// Self-checking bench for alu_issue_ctrl. The arithmetic cells are modelled
// behaviourally from cell_a/cell_b/cmp_sel. Expected results come from a
// plain-arithmetic reference function plus a tracked accumulator value.
// ---------------------------------------------------------------------------
module tb_alu_issue_ctrl;

    localparam int W = 2;

    localparam logic [2:0] OP_ADD    = 3'd0;
    localparam logic [2:0] OP_SUB    = 3'd1;
    localparam logic [2:0] OP_MUL    = 3'd2;
    localparam logic [2:0] OP_DIV    = 3'd3;
    localparam logic [2:0] OP_CMP_EQ = 3'd4;
    localparam logic [2:0] OP_CMP_GT = 3'd5;
    localparam logic [2:0] OP_CMP_LT = 3'd6;
    localparam logic [2:0] OP_CLRACC = 3'd7;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [7:0]  in_a, in_b;
    logic        in_use_acc;
    logic [7:0]  cell_a, cell_b;
    logic [1:0]  cmp_sel;
    logic [7:0]  sum_in, minus_in, quot_in, rem_in;
    logic [15:0] mul_in;
    logic        cmp_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic        out_zero, out_divz;
    logic [7:0]  acc;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] acc_m;
    logic [1:0] cmp_sel_m;

    always #5 clk = ~clk;

    // Behavioural cells; divide by zero returns junk the controller must mask.
    assign sum_in   = cell_a + cell_b;
    assign minus_in = cell_a - cell_b;
    assign mul_in   = 16'(cell_a) * 16'(cell_b);
    assign quot_in  = (cell_b == 8'h00) ? 8'hFF : cell_a / cell_b;
    assign rem_in   = (cell_b == 8'h00) ? 8'hA5 : cell_a % cell_b;
    assign cmp_in   = (cmp_sel == 2'd0) ? (cell_a == cell_b) :
                      (cmp_sel == 2'd1) ? (cell_a >  cell_b) :
                      (cmp_sel == 2'd2) ? (cell_a <  cell_b) : 1'b0;

    alu_issue_ctrl #(.MULDIV_WAIT(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_use_acc (in_use_acc),
        .cell_a     (cell_a),
        .cell_b     (cell_b),
        .cmp_sel    (cmp_sel),
        .sum_in     (sum_in),
        .minus_in   (minus_in),
        .quot_in    (quot_in),
        .rem_in     (rem_in),
        .mul_in     (mul_in),
        .cmp_in     (cmp_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_zero   (out_zero),
        .out_divz   (out_divz),
        .acc        (acc)
    );

    // Reference: result of an op on (a, b) by plain integer arithmetic.
    function automatic logic [15:0] ref_result(input int op, input int a, input int b);
        case (op)
            0: return 16'((a + b) % 256);
            1: return 16'((a - b + 256) % 256);
            2: return 16'(a * b);
            3: return (b == 0) ? 16'h0000 : 16'((a % b) * 256 + a / b);
            4: return (a == b) ? 16'h0001 : 16'h0000;
            5: return (a >  b) ? 16'h0001 : 16'h0000;
            6: return (a <  b) ? 16'h0001 : 16'h0000;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic int exp_latency(input logic [2:0] op);
        return (op == OP_MUL || op == OP_DIV) ? 2 + W : 2;
    endfunction

    // Drive one operation and observe it. lat = edge index (relative to the
    // accept edge) at which out_valid is first sampled high.
    task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic ua, input int hold,
                          output logic [15:0] r, output logic z, output logic dz,
                          output logic [7:0] av, output logic [1:0] cs,
                          output int lat, output bit stable, output bit ok_hs);
        logic [7:0] ca, cb;
        int guard;
        ok_hs  = 1'b1;
        stable = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_use_acc = ua;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) ok_hs = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        ca = cell_a;
        cb = cell_b;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (cell_a !== ca || cell_b !== cb) stable = 1'b0;
        end while (!out_valid && lat < 50);
        if (!out_valid) ok_hs = 1'b0;
        r = out_result; z = out_zero; dz = out_divz; av = acc; cs = cmp_sel;
        repeat (hold) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        if (out_valid) ok_hs = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_in_ready_low: got %b expected 0", in_ready);
        end
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({in_ready, out_valid, out_zero, out_divz} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_flags: got rdy/val/zero/divz=%b expected 1000",
                     {in_ready, out_valid, out_zero, out_divz});
        end
        n_checks++;
        if ({out_result, acc, cell_a, cell_b, cmp_sel} !== 42'd0) begin
            n_fail++;
            $display("FAIL reset_regs: got res=%h acc=%h a=%h b=%h sel=%0d expected all 0",
                     out_result, acc, cell_a, cell_b, cmp_sel);
        end
        acc_m = 8'h00;
        cmp_sel_m = 2'd0;
        $display("reset: done");
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic        ua;
        logic [15:0] r;
        logic        dz;
    } vec_t;

    task automatic test_directed();
        vec_t v[10];
        logic [15:0] r; logic z, dz; logic [7:0] av; logic [1:0] cs;
        int lat; bit stable, ok;
        v[0] = '{OP_ADD,    8'd200, 8'd100, 1'b0, 16'h002C, 1'b0};
        v[1] = '{OP_SUB,    8'd5,   8'd10,  1'b0, 16'h00FB, 1'b0};
        v[2] = '{OP_CMP_GT, 8'd9,   8'd3,   1'b0, 16'h0001, 1'b0};
        v[3] = '{OP_CMP_EQ, 8'd9,   8'd3,   1'b0, 16'h0000, 1'b0};
        v[4] = '{OP_MUL,    8'd255, 8'd255, 1'b0, 16'hFE01, 1'b0};
        v[5] = '{OP_DIV,    8'd200, 8'd7,   1'b0, 16'h041C, 1'b0};
        v[6] = '{OP_DIV,    8'd9,   8'd0,   1'b0, 16'h0000, 1'b1};
        v[7] = '{OP_ADD,    8'd3,   8'd4,   1'b0, 16'h0007, 1'b0};
        v[8] = '{OP_ADD,    8'd99,  8'd10,  1'b1, 16'h0011, 1'b0};
        v[9] = '{OP_CLRACC, 8'd77,  8'd88,  1'b0, 16'h0000, 1'b0};
        for (int i = 0; i < 10; i++) begin
            run_op(v[i].op, v[i].a, v[i].b, v[i].ua, 0, r, z, dz, av, cs, lat, stable, ok);
            $display("directed %0d: op=%0d a=%0d b=%0d ua=%0b -> res=%h zero=%b divz=%b acc=%h lat=%0d",
                     i, v[i].op, v[i].a, v[i].b, v[i].ua, r, z, dz, av, lat);
            n_checks++;
            if (!ok) begin
                n_fail++;
                $display("FAIL dir_handshake[%0d]: handshake timeout or out_valid stuck", i);
            end
            n_checks++;
            if (r !== v[i].r) begin
                n_fail++;
                $display("FAIL dir_result[%0d]: got %h expected %h", i, r, v[i].r);
            end
            n_checks++;
            if (z !== (v[i].r == 16'h0000) || dz !== v[i].dz) begin
                n_fail++;
                $display("FAIL dir_flags[%0d]: got zero=%b divz=%b expected zero=%b divz=%b",
                         i, z, dz, (v[i].r == 16'h0000), v[i].dz);
            end
            n_checks++;
            if (av !== v[i].r[7:0]) begin
                n_fail++;
                $display("FAIL dir_acc[%0d]: got %h expected %h", i, av, v[i].r[7:0]);
            end
            n_checks++;
            if (lat != exp_latency(v[i].op)) begin
                n_fail++;
                $display("FAIL dir_latency[%0d]: got %0d expected %0d", i, lat, exp_latency(v[i].op));
            end
            n_checks++;
            if (!stable) begin
                n_fail++;
                $display("FAIL dir_operand_hold[%0d]: cell_a/cell_b changed during EXEC", i);
            end
        end
        acc_m = 8'h00;
        cmp_sel_m = 2'd0;   // last compare in the table was CMP_EQ
    endtask

    task automatic test_random();
        logic [2:0] op; logic [7:0] a, b, a_eff; logic ua; int hold;
        logic [15:0] r, er; logic z, dz, edz; logic [7:0] av; logic [1:0] cs;
        int lat; bit stable, ok;
        for (int i = 0; i < 40; i++) begin
            op   = 3'($urandom_range(0, 7));
            a    = 8'($urandom_range(0, 255));
            b    = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 4) == 0) b = 8'h00;
            ua   = 1'($urandom_range(0, 1));
            hold = $urandom_range(0, 2);
            a_eff = ua ? acc_m : a;
            er  = ref_result(int'(op), int'(a_eff), int'(b));
            edz = (op == OP_DIV) && (b == 8'h00);
            if (op == OP_CMP_EQ) cmp_sel_m = 2'd0;
            if (op == OP_CMP_GT) cmp_sel_m = 2'd1;
            if (op == OP_CMP_LT) cmp_sel_m = 2'd2;
            run_op(op, a, b, ua, hold, r, z, dz, av, cs, lat, stable, ok);
            $display("random %0d: op=%0d a=%0d b=%0d ua=%0b -> res=%h expected %h lat=%0d",
                     i, op, a_eff, b, ua, r, er, lat);
            n_checks++;
            if (!ok || !stable) begin
                n_fail++;
                $display("FAIL rnd_protocol[%0d]: handshake ok=%0b operands stable=%0b", i, ok, stable);
            end
            n_checks++;
            if (r !== er || z !== (er == 16'h0000) || dz !== edz) begin
                n_fail++;
                $display("FAIL rnd_result[%0d]: got %h z=%b dz=%b expected %h z=%b dz=%b",
                         i, r, z, dz, er, (er == 16'h0000), edz);
            end
            acc_m = er[7:0];
            n_checks++;
            if (av !== acc_m || cs !== cmp_sel_m) begin
                n_fail++;
                $display("FAIL rnd_acc_sel[%0d]: got acc=%h sel=%0d expected acc=%h sel=%0d",
                         i, av, cs, acc_m, cmp_sel_m);
            end
            n_checks++;
            if (lat != exp_latency(op)) begin
                n_fail++;
                $display("FAIL rnd_latency[%0d]: got %0d expected %0d", i, lat, exp_latency(op));
            end
        end
    endtask

    task automatic test_back_pressure();
        int guard;
        @(negedge clk);
        in_valid = 1'b1; in_op = OP_ADD; in_a = 8'd1; in_b = 8'd2; in_use_acc = 1'b0;
        @(posedge clk);
        #1;
        // Next op is offered immediately and held until accepted.
        in_op = OP_SUB; in_a = 8'd50; in_b = 8'd20;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!out_valid && guard < 50);
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_first_valid: timeout waiting for out_valid");
        end
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_result !== 16'h0003 || cell_a !== 8'd1) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got val=%b rdy=%b res=%h cell_a=%0d expected 1 0 0003 1",
                         c, out_valid, in_ready, out_result, cell_a);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: got val=%b rdy=%b expected val=0 rdy=1", out_valid, in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n_checks++;
        if (cell_a !== 8'd50 || cell_b !== 8'd20) begin
            n_fail++;
            $display("FAIL bp_accept_held: got a=%0d b=%0d expected 50 20", cell_a, cell_b);
        end
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!out_valid && guard < 50);
        n_checks++;
        if (out_valid !== 1'b1 || out_result !== 16'd30 || acc !== 8'd30) begin
            n_fail++;
            $display("FAIL bp_second_result: got val=%b res=%h acc=%h expected 1 001e 1e",
                     out_valid, out_result, acc);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        acc_m = 8'd30;
        $display("back_pressure: first=0003 second=%h", out_result);
    endtask

    task automatic test_reset_mid_exec();
        bit seen_valid;
        @(negedge clk);
        in_valid = 1'b1; in_op = OP_MUL; in_a = 8'd12; in_b = 8'd13; in_use_acc = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_exec_in_ready: got %b expected 0", in_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if ({out_valid, out_zero, out_divz} !== 3'b000 ||
            {out_result, acc, cell_a, cell_b, cmp_sel} !== 42'd0) begin
            n_fail++;
            $display("FAIL rst_exec_state: got val=%b res=%h acc=%h a=%h b=%h expected all 0",
                     out_valid, out_result, acc, cell_a, cell_b);
        end
        seen_valid = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_valid) seen_valid = 1'b1;
        end
        n_checks++;
        if (seen_valid || acc !== 8'h00 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_exec_after: got seen_valid=%0b acc=%h rdy=%b expected 0 00 1",
                     seen_valid, acc, in_ready);
        end
        acc_m = 8'h00;
        cmp_sel_m = 2'd0;
        $display("reset_mid_exec: acc=%h out_valid seen=%0b", acc, seen_valid);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_op = 3'd0; in_a = 8'd0; in_b = 8'd0;
        in_use_acc = 1'b0; out_ready = 1'b0;
        acc_m = 8'h00; cmp_sel_m = 2'd0;
        test_reset();
        test_directed();
        test_random();
        test_back_pressure();
        test_reset_mid_exec();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
